// File: rtl/uc_pkg.sv
// rtl/uc_pkg.sv - states, control-word bit map and opcode constants for the multicycle control unit
package uc_pkg;

    typedef enum logic [5:0] {
        IDLE     = 6'd0,
        FETCH1   = 6'd1,
        FETCH2   = 6'd2,
        DECODE   = 6'd3,
        EXEC_ALU = 6'd4,
        MEM_ADDR = 6'd5,
        MEM_INC  = 6'd6,
        MEM_WDR  = 6'd7,
        MEM_ACC  = 6'd8,
        MEM_WB   = 6'd9,
        BR_SALTO = 6'd10,
        CALL1    = 6'd11,
        CALL2    = 6'd12,
        CALL3    = 6'd13,
        CALL4    = 6'd14,
        RET1     = 6'd15,
        RET2     = 6'd16,
        RET3     = 6'd17,
        TRAP     = 6'd63
    } estado_t;

    localparam int LS_SELDR    = 10;
    localparam int LS_LOADDR   = 9;
    localparam int LS_SELAR    = 8;
    localparam int LS_LOADAR   = 7;
    localparam int LS_SELPC    = 5;
    localparam int LS_LOADPC   = 4;
    localparam int LS_LOADIR   = 3;
    localparam int LS_LOADCR   = 2;
    localparam int LS_WRITESEL = 1;
    localparam int LS_WRITEEN  = 0;

    localparam logic [1:0] SELPC_INC   = 2'b00;
    localparam logic [1:0] SELPC_PC    = 2'b01;
    localparam logic [1:0] SELPC_SALTO = 2'b10;
    localparam logic [1:0] SELPC_DR    = 2'b11;

    localparam logic [1:0] CLS_ALU = 2'b00;
    localparam logic [1:0] CLS_MEM = 2'b01;
    localparam logic [1:0] CLS_BR  = 2'b10;

    localparam logic [1:0] BR_JMP  = 2'b00;
    localparam logic [1:0] BR_COND = 2'b01;
    localparam logic [1:0] BR_CALL = 2'b10;

    localparam logic [1:0] MODO_SUMA   = 2'b01;
    localparam logic [1:0] MODO_INC    = 2'b10;
    localparam logic [1:0] MODO_ILEGAL = 2'b11;

    localparam logic [3:0] FUN_PASA_A = 4'b1000;
    localparam logic [3:0] FUN_SUMA   = 4'b0101;
    localparam logic [3:0] FUN_INC    = 4'b0100;
    localparam logic [3:0] FUN_DEC    = 4'b0111;

    localparam logic [1:0] EXC_NINGUNA = 2'b00;
    localparam logic [1:0] EXC_ILEGAL  = 2'b01;
    localparam logic [1:0] EXC_TIEMPO  = 2'b10;

    // States that hold a memory request open until MemListo
    function automatic logic es_espera(input estado_t e);
        return (e == FETCH1) || (e == MEM_ACC) || (e == CALL3) || (e == RET2);
    endfunction

endpackage

// File: rtl/uc_espera_mem.sv
// rtl/uc_espera_mem.sv - memory wait counter; flags the last allowed not-ready cycle
module uc_espera_mem #(
    parameter int TIMEOUT = 15
) (
    input  logic Reloj,
    input  logic Reiniciar,
    input  logic clear,
    input  logic run,
    input  logic listo,
    output logic vencido
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMITE = CW'(TIMEOUT - 1);

    logic [CW-1:0] cuenta;

    always_ff @(posedge Reloj or negedge Reiniciar) begin
        if (!Reiniciar) begin
            cuenta <= '0;
        end else if (clear) begin
            cuenta <= '0;
        end else if (run && !listo) begin
            cuenta <= cuenta + 1'b1;
        end
    end

    // Completion has priority: only a not-ready cycle can expire the wait
    assign vencido = run && !listo && (cuenta == LIMITE);

endmodule

// File: rtl/unidad_control_multiciclo.sv
// rtl/unidad_control_multiciclo.sv - multicycle fetch/decode/execute control FSM with branches, call/return and traps
module unidad_control_multiciclo #(
    parameter int IW      = 16,
    parameter int RAW     = 3,
    parameter int FUNW    = 4,
    parameter int TIMEOUT = 15,
    parameter logic [RAW-1:0] SP_REG = {RAW{1'b1}}
) (
    input  logic            Reloj,
    input  logic            Reiniciar,
    input  logic [IW-1:0]   Instruccion,
    input  logic [3:0]      Banderas,
    input  logic            MemListo,
    output logic            MemLectura,
    output logic            MemEscritura,
    output logic [10:0]     LoadSelect,
    output logic [RAW-1:0]  WriteAddress,
    output logic [RAW-1:0]  ReadAddressA,
    output logic [RAW-1:0]  ReadAddressB,
    output logic [FUNW-1:0] Fun,
    output logic            Excepcion,
    output logic [1:0]      ExcCodigo
);
    import uc_pkg::*;

    estado_t est, nxt;
    logic    vencido;

    logic [1:0]      cls, br_op, modo;
    logic            esc;
    logic [FUNW-1:0] fun_i;
    logic [RAW-1:0]  rd, ra, rb;

    assign cls   = Instruccion[IW-1:IW-2];
    assign br_op = Instruccion[13:12];
    assign esc   = Instruccion[11];
    assign modo  = Instruccion[10:9];
    assign fun_i = Instruccion[3*RAW+FUNW-1:3*RAW];
    assign rd    = Instruccion[3*RAW-1:2*RAW];
    assign ra    = Instruccion[2*RAW-1:RAW];
    assign rb    = Instruccion[RAW-1:0];

    uc_espera_mem #(.TIMEOUT(TIMEOUT)) u_espera (
        .Reloj     (Reloj),
        .Reiniciar (Reiniciar),
        .clear     (nxt != est),
        .run       (es_espera(est)),
        .listo     (MemListo),
        .vencido   (vencido)
    );

    always_comb begin
        nxt = est;
        case (est)
            IDLE:     nxt = FETCH1;
            FETCH1:   if (MemListo) nxt = FETCH2; else if (vencido) nxt = TRAP;
            FETCH2:   nxt = DECODE;
            DECODE: begin
                case (cls)
                    CLS_ALU: nxt = EXEC_ALU;
                    // An illegal addressing mode is caught here so MEM_ADDR never drives a bogus address
                    CLS_MEM: nxt = (modo == MODO_ILEGAL) ? TRAP : MEM_ADDR;
                    CLS_BR: begin
                        case (br_op)
                            BR_JMP:  nxt = BR_SALTO;
                            BR_COND: nxt = (Banderas[modo] ^ esc) ? BR_SALTO : FETCH1;
                            BR_CALL: nxt = CALL1;
                            default: nxt = RET1;
                        endcase
                    end
                    default: nxt = TRAP;
                endcase
            end
            EXEC_ALU: nxt = FETCH1;
            MEM_ADDR: nxt = (modo == MODO_INC) ? MEM_INC : (esc ? MEM_WDR : MEM_ACC);
            MEM_INC:  nxt = esc ? MEM_WDR : MEM_ACC;
            MEM_WDR:  nxt = MEM_ACC;
            MEM_ACC:  if (MemListo) nxt = esc ? FETCH1 : MEM_WB; else if (vencido) nxt = TRAP;
            MEM_WB:   nxt = FETCH1;
            BR_SALTO: nxt = FETCH1;
            CALL1:    nxt = CALL2;
            CALL2:    nxt = CALL3;
            CALL3:    if (MemListo) nxt = CALL4; else if (vencido) nxt = TRAP;
            CALL4:    nxt = FETCH1;
            RET1:     nxt = RET2;
            RET2:     if (MemListo) nxt = RET3; else if (vencido) nxt = TRAP;
            RET3:     nxt = FETCH1;
            TRAP:     nxt = TRAP;
            default:  nxt = TRAP;
        endcase
    end

    logic [10:0]     ls_d;
    logic            mr_d, mw_d;
    logic [RAW-1:0]  wa_d, raa_d, rab_d;
    logic [FUNW-1:0] fun_d;

    // Control word of the state being entered; registered below so outputs are glitch-free Moore signals
    always_comb begin
        ls_d  = '0;
        mr_d  = 1'b0;
        mw_d  = 1'b0;
        wa_d  = '0;
        raa_d = '0;
        rab_d = '0;
        fun_d = '0;
        case (nxt)
            FETCH1: begin
                mr_d = 1'b1;
                ls_d[LS_LOADAR] = 1'b1;
            end
            FETCH2: begin
                ls_d[LS_LOADIR] = 1'b1;
                ls_d[LS_LOADPC] = 1'b1;
                ls_d[LS_SELPC +: 2] = SELPC_INC;
            end
            EXEC_ALU: begin
                ls_d[LS_WRITEEN] = 1'b1;
                ls_d[LS_LOADCR]  = 1'b1;
                wa_d  = rd;
                raa_d = ra;
                rab_d = rb;
                fun_d = fun_i;
            end
            MEM_ADDR: begin
                ls_d[LS_LOADAR] = 1'b1;
                ls_d[LS_SELAR]  = 1'b1;
                raa_d = ra;
                if (modo == MODO_SUMA) begin
                    rab_d = rb;
                    fun_d = FUNW'(FUN_SUMA);
                end else begin
                    fun_d = FUNW'(FUN_PASA_A);
                end
            end
            MEM_INC: begin
                ls_d[LS_WRITEEN] = 1'b1;
                wa_d  = ra;
                raa_d = ra;
                fun_d = FUNW'(FUN_INC);
            end
            MEM_WDR: begin
                ls_d[LS_LOADDR] = 1'b1;
                ls_d[LS_SELDR]  = 1'b1;
                raa_d = rd;
                fun_d = FUNW'(FUN_PASA_A);
            end
            MEM_ACC: begin
                mr_d = !esc;
                mw_d = esc;
            end
            MEM_WB: begin
                ls_d[LS_LOADDR]   = 1'b1;
                ls_d[LS_WRITESEL] = 1'b1;
                ls_d[LS_WRITEEN]  = 1'b1;
                wa_d = rd;
            end
            BR_SALTO, CALL4: begin
                ls_d[LS_LOADPC] = 1'b1;
                ls_d[LS_SELPC +: 2] = SELPC_SALTO;
                raa_d = ra;
            end
            CALL1: begin
                ls_d[LS_WRITEEN] = 1'b1;
                wa_d  = SP_REG;
                raa_d = SP_REG;
                fun_d = FUNW'(FUN_DEC);
            end
            CALL2: begin
                ls_d[LS_LOADAR] = 1'b1;
                ls_d[LS_SELAR]  = 1'b1;
                ls_d[LS_LOADDR] = 1'b1;
                ls_d[LS_SELDR]  = 1'b1;
                ls_d[LS_SELPC +: 2] = SELPC_PC;
                raa_d = SP_REG;
                fun_d = FUNW'(FUN_PASA_A);
            end
            CALL3: mw_d = 1'b1;
            RET1: begin
                ls_d[LS_LOADAR] = 1'b1;
                ls_d[LS_SELAR]  = 1'b1;
                raa_d = SP_REG;
                fun_d = FUNW'(FUN_PASA_A);
            end
            // DR reloads every waiting cycle; the value latched on the MemListo cycle is the one kept
            RET2: begin
                mr_d = 1'b1;
                ls_d[LS_LOADDR] = 1'b1;
            end
            RET3: begin
                ls_d[LS_LOADPC]  = 1'b1;
                ls_d[LS_SELPC +: 2] = SELPC_DR;
                ls_d[LS_WRITEEN] = 1'b1;
                wa_d  = SP_REG;
                raa_d = SP_REG;
                fun_d = FUNW'(FUN_INC);
            end
            default: ;
        endcase
    end

    always_ff @(posedge Reloj or negedge Reiniciar) begin
        if (!Reiniciar) begin
            est          <= IDLE;
            MemLectura   <= 1'b0;
            MemEscritura <= 1'b0;
            LoadSelect   <= '0;
            WriteAddress <= '0;
            ReadAddressA <= '0;
            ReadAddressB <= '0;
            Fun          <= '0;
            Excepcion    <= 1'b0;
            ExcCodigo    <= EXC_NINGUNA;
        end else begin
            est          <= nxt;
            MemLectura   <= mr_d;
            MemEscritura <= mw_d;
            LoadSelect   <= ls_d;
            WriteAddress <= wa_d;
            ReadAddressA <= raa_d;
            ReadAddressB <= rab_d;
            Fun          <= fun_d;
            Excepcion    <= (nxt == TRAP);
            if (nxt == TRAP && est != TRAP) begin
                ExcCodigo <= (est == DECODE) ? EXC_ILEGAL : EXC_TIEMPO;
            end
        end
    end

endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// tb/tb_unidad_control_multiciclo.sv - random-instruction bench with a per-instruction micro-sequence reference model
module tb_unidad_control_multiciclo;

    localparam int TIMEOUT = 15;
    localparam logic [2:0] SP = 3'b111;

    localparam logic [10:0] LWE = 11'h001, LWS = 11'h002, LCR = 11'h004, LIR = 11'h008;
    localparam logic [10:0] LPC = 11'h010, PC01 = 11'h020, PC10 = 11'h040, PC11 = 11'h060;
    localparam logic [10:0] LAR = 11'h080, SAR = 11'h100, LDR = 11'h200, SDR = 11'h400;
    localparam logic [3:0]  F_PASA = 4'b1000, F_SUMA = 4'b0101, F_INC = 4'b0100, F_DEC = 4'b0111;

    logic        Reloj = 1'b0;
    logic        Reiniciar;
    logic [15:0] Instruccion;
    logic [3:0]  Banderas;
    logic        MemListo;
    logic        MemLectura, MemEscritura, Excepcion;
    logic [10:0] LoadSelect;
    logic [2:0]  WriteAddress, ReadAddressA, ReadAddressB;
    logic [3:0]  Fun;
    logic [1:0]  ExcCodigo;

    unidad_control_multiciclo dut (
        .Reloj        (Reloj),
        .Reiniciar    (Reiniciar),
        .Instruccion  (Instruccion),
        .Banderas     (Banderas),
        .MemListo     (MemListo),
        .MemLectura   (MemLectura),
        .MemEscritura (MemEscritura),
        .LoadSelect   (LoadSelect),
        .WriteAddress (WriteAddress),
        .ReadAddressA (ReadAddressA),
        .ReadAddressB (ReadAddressB),
        .Fun          (Fun),
        .Excepcion    (Excepcion),
        .ExcCodigo    (ExcCodigo)
    );

    always #5 Reloj = ~Reloj;

    logic [28:0] obs;
    assign obs = {MemLectura, MemEscritura, LoadSelect, WriteAddress, ReadAddressA, ReadAddressB,
                  Fun, Excepcion, ExcCodigo};

    typedef struct {
        logic        wt;
        logic        tr;
        logic [28:0] v;
    } paso_t;

    paso_t q[$];
    int total = 0;
    int bad = 0;
    int wcnt = 0;
    int trapcyc = 0;
    logic atascado = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic step();
        @(posedge Reloj);
        @(negedge Reloj);
    endtask

    function automatic logic [28:0] mkv(input logic mr, input logic mw, input logic [10:0] ls,
                                        input logic [2:0] wa, input logic [2:0] raa,
                                        input logic [2:0] rab, input logic [3:0] f);
        return {mr, mw, ls, wa, raa, rab, f, 3'b000};
    endfunction

    function automatic logic [28:0] trapv(input logic [1:0] code);
        return {26'd0, 1'b1, code};
    endfunction

    task automatic push(input logic wt, input logic tr, input logic [28:0] v);
        paso_t p;
        p.wt = wt;
        p.tr = tr;
        p.v  = v;
        q.push_back(p);
    endtask

    // Expected cycle-by-cycle control words for one instruction, starting at its fetch
    task automatic build(input logic [15:0] i, input logic [3:0] fl);
        logic [1:0] cls, sub, mode;
        logic w;
        logic [2:0] rd, ra, rb;
        cls = i[15:14]; sub = i[13:12]; w = i[11]; mode = i[10:9];
        rd = i[8:6]; ra = i[5:3]; rb = i[2:0];
        push(1, 0, mkv(1, 0, LAR, 0, 0, 0, 0));
        push(0, 0, mkv(0, 0, LIR | LPC, 0, 0, 0, 0));
        push(0, 0, '0);
        case (cls)
            2'b00: push(0, 0, mkv(0, 0, LWE | LCR, rd, ra, rb, i[12:9]));
            2'b01: begin
                if (mode == 2'b11) begin
                    push(0, 1, trapv(2'b01));
                end else begin
                    push(0, 0, mkv(0, 0, LAR | SAR, 0, ra, (mode == 2'b01) ? rb : 3'd0,
                                   (mode == 2'b01) ? F_SUMA : F_PASA));
                    if (mode == 2'b10) push(0, 0, mkv(0, 0, LWE, ra, ra, 0, F_INC));
                    if (w) begin
                        push(0, 0, mkv(0, 0, LDR | SDR, 0, rd, 0, F_PASA));
                        push(1, 0, mkv(0, 1, 0, 0, 0, 0, 0));
                    end else begin
                        push(1, 0, mkv(1, 0, 0, 0, 0, 0, 0));
                        push(0, 0, mkv(0, 0, LDR | LWS | LWE, rd, 0, 0, 0));
                    end
                end
            end
            2'b10: begin
                case (sub)
                    2'b00: push(0, 0, mkv(0, 0, LPC | PC10, 0, ra, 0, 0));
                    2'b01: if (fl[mode] ^ w) push(0, 0, mkv(0, 0, LPC | PC10, 0, ra, 0, 0));
                    2'b10: begin
                        push(0, 0, mkv(0, 0, LWE, SP, SP, 0, F_DEC));
                        push(0, 0, mkv(0, 0, LAR | SAR | LDR | SDR | PC01, 0, SP, 0, F_PASA));
                        push(1, 0, mkv(0, 1, 0, 0, 0, 0, 0));
                        push(0, 0, mkv(0, 0, LPC | PC10, 0, ra, 0, 0));
                    end
                    default: begin
                        push(0, 0, mkv(0, 0, LAR | SAR, 0, SP, 0, F_PASA));
                        push(1, 0, mkv(1, 0, LDR, 0, 0, 0, 0));
                        push(0, 0, mkv(0, 0, LPC | PC11 | LWE, SP, SP, 0, F_INC));
                    end
                endcase
            end
            default: push(0, 1, trapv(2'b01));
        endcase
    endtask

    function automatic logic [15:0] gen();
        logic [15:0] i;
        int r;
        i = 16'($urandom);
        r = $urandom_range(0, 99);
        i[15:14] = (r < 30) ? 2'b00 : (r < 65) ? 2'b01 : (r < 96) ? 2'b10 : 2'b11;
        if (i[15:14] == 2'b01 && i[10:9] == 2'b11 && $urandom_range(0, 3) != 0)
            i[10:9] = 2'($urandom_range(0, 2));
        return i;
    endfunction

    task automatic next_wait();
        wcnt = 0;
        atascado = ($urandom_range(0, 19) == 0);
    endtask

    task automatic do_reset();
        Reiniciar = 1'b0;
        #1;
        chk("reset_now", {3'd0, obs}, 32'd0);
        step();
        chk("reset_held", {3'd0, obs}, 32'd0);
        Reiniciar = 1'b1;
        q.delete();
        next_wait();
        trapcyc = 0;
        step();
    endtask

    initial begin
        int n;
        logic listo;
        Reiniciar   = 1'b0;
        MemListo    = 1'b1;
        Banderas    = 4'b0000;
        Instruccion = 16'h0A53;
        step();
        step();
        chk("rst_ls", {21'd0, LoadSelect}, 32'd0);
        chk("rst_mem", {30'd0, MemLectura, MemEscritura}, 32'd0);
        chk("rst_exc", {29'd0, Excepcion, ExcCodigo}, 32'd0);
        Reiniciar = 1'b1;
        step();
        chk("f1_mr", {31'd0, MemLectura}, 32'd1);
        chk("f1_ls", {21'd0, LoadSelect}, 32'h080);
        step();
        chk("f2_ls", {21'd0, LoadSelect}, 32'h018);
        step();
        chk("dec_ls", {21'd0, LoadSelect}, 32'd0);
        step();
        chk("alu_ls", {21'd0, LoadSelect}, 32'h005);
        chk("alu_wa", {29'd0, WriteAddress}, 32'd1);
        chk("alu_ra", {29'd0, ReadAddressA}, 32'd2);
        chk("alu_rb", {29'd0, ReadAddressB}, 32'd3);
        chk("alu_fun", {28'd0, Fun}, 32'h5);
        step();
        chk("cyc5_fetch", {31'd0, MemLectura}, 32'd1);

        MemListo = 1'b0;
        n = 0;
        while (!Excepcion && n < 40) begin
            step();
            n++;
        end
        chk("timeout_cycles", n, TIMEOUT);
        chk("timeout_code", {30'd0, ExcCodigo}, 32'h2);
        chk("timeout_dropped", {31'd0, MemLectura}, 32'd0);

        do_reset();
        Instruccion = 16'hC000;
        MemListo = 1'b1;
        repeat (3) step();
        chk("illegal_exc", {31'd0, Excepcion}, 32'd1);
        chk("illegal_code", {30'd0, ExcCodigo}, 32'h1);
        MemListo = 1'b0;
        step();
        MemListo = 1'b1;
        step();
        chk("trap_hold", {3'd0, obs}, 32'h5);

        do_reset();
        for (int c = 0; c < 6000; c++) begin
            if (q.size() == 0) begin
                Instruccion = gen();
                Banderas = 4'($urandom);
                build(Instruccion, Banderas);
            end
            chk("cycle", {3'd0, obs}, {3'd0, q[0].v});
            if (q[0].tr) begin
                MemListo = 1'($urandom);
                trapcyc++;
                if (trapcyc >= 3) begin
                    do_reset();
                    continue;
                end
            end else if (q[0].wt) begin
                listo = atascado ? 1'b0 : ($urandom_range(0, 2) != 0);
                MemListo = listo;
                if (listo) begin
                    void'(q.pop_front());
                    next_wait();
                end else begin
                    wcnt++;
                    if (wcnt == TIMEOUT) begin
                        q.delete();
                        push(0, 1, trapv(2'b10));
                    end
                end
            end else begin
                MemListo = 1'($urandom);
                void'(q.pop_front());
                next_wait();
            end
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
                continue;
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
